// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared types and constants for the sorter front-end
package sorter_pkg;

  localparam int MAX_DATALENGTH = 32;
  localparam int NUM_QUADS      = MAX_DATALENGTH / 4;

  typedef struct packed {
    logic       channel_32;
    logic [1:0] channel_16;
    logic [3:0] channel_8;
    logic [7:0] channel_4;
  } channel_t;

  typedef struct packed {
    logic     sign_ctrl;
    channel_t ch;
  } ctrl_t;

  typedef enum logic [1:0] {SZ4, SZ8, SZ16, SZ32} job_size_e;

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, BUSY} sched_state_e;

  // Number of quads a job of the given size occupies (also its alignment).
  function automatic int quads_of(job_size_e s);
    return 1 << s;
  endfunction

endpackage

// File: rtl/sorter_slot_alloc.sv
// rtl/sorter_slot_alloc.sv - first-fit aligned quad allocator for one job
module sorter_slot_alloc
  import sorter_pkg::*;
(
  input  logic [NUM_QUADS-1:0] i_occ,
  input  job_size_e            i_size,
  output logic                 o_fit,
  output logic [2:0]           o_slot,
  output logic [NUM_QUADS-1:0] o_occ_next,
  output channel_t             o_ch_set
);

  logic [NUM_QUADS-1:0] w_base;
  logic [NUM_QUADS-1:0] w_blk;

  always_comb begin
    w_base   = NUM_QUADS'((1 << quads_of(i_size)) - 1);
    o_fit    = 1'b0;
    o_slot   = 3'd0;
    w_blk    = '0;
    o_ch_set = '0;
    // Descending scan so the lowest free aligned index is the one that sticks.
    for (int q = NUM_QUADS - 1; q >= 0; q--) begin
      if (((q % quads_of(i_size)) == 0) && ((i_occ & (w_base << q)) == '0)) begin
        o_fit  = 1'b1;
        o_slot = 3'(q);
        w_blk  = w_base << q;
      end
    end
    o_occ_next = i_occ | w_blk;
    if (o_fit) begin
      case (i_size)
        SZ4:     o_ch_set.channel_4  = 8'b1 << o_slot;
        SZ8:     o_ch_set.channel_8  = 4'b1 << o_slot[2:1];
        SZ16:    o_ch_set.channel_16 = 2'b1 << o_slot[2];
        default: o_ch_set.channel_32 = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/sorter_batch_scheduler.sv
// rtl/sorter_batch_scheduler.sv - packs sort jobs into quad slots and times one sorter batch
module sorter_batch_scheduler
  import sorter_pkg::*;
#(
  parameter int SORT_LATENCY  = 5,
  parameter int BATCH_TIMEOUT = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_size_i,
  input  logic       req_sign_i,
  output logic [2:0] req_slot_o,
  input  logic       flush_i,
  output logic       sort_start_o,
  output ctrl_t      sort_ctrl_o,
  output logic       done_valid_o,
  output channel_t   done_channel_o,
  output logic       done_sign_o,
  output logic       idle_o
);

  localparam int TW = (BATCH_TIMEOUT > 1) ? $clog2(BATCH_TIMEOUT) : 1;
  localparam int LW = $clog2(SORT_LATENCY + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BATCH_TIMEOUT - 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(SORT_LATENCY);

  sched_state_e         r_state;
  sched_state_e         w_state_next;
  logic [NUM_QUADS-1:0] r_occ;
  logic [TW-1:0]        r_timer;
  logic [LW-1:0]        r_lat;
  ctrl_t                r_ctrl;

  logic                 w_fit;
  logic [2:0]           w_slot;
  logic [NUM_QUADS-1:0] w_occ_next;
  channel_t             w_ch_set;
  logic                 w_ready;
  logic                 w_hs;
  logic                 w_close;
  logic                 w_done;

  sorter_slot_alloc u_alloc (
    .i_occ      (r_occ),
    .i_size     (job_size_e'(req_size_i)),
    .o_fit      (w_fit),
    .o_slot     (w_slot),
    .o_occ_next (w_occ_next),
    .o_ch_set   (w_ch_set)
  );

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      COLLECT: w_ready = w_fit && (req_sign_i == r_ctrl.sign_ctrl) && !(&r_occ);
      default: w_ready = 1'b0;
    endcase
  end

  assign req_ready_o = w_ready && !rst_i;
  assign w_hs        = req_valid_i && req_ready_o;
  assign w_done      = (r_state == BUSY) && (r_lat == LW'(1));

  always_comb begin
    w_state_next = r_state;
    w_close      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_hs) w_state_next = COLLECT;
      end
      COLLECT: begin
        // A refused request closes the batch so it can be served by the next one.
        w_close = (w_hs && (&w_occ_next)) || (r_timer == TIMER_LAST) ||
                  flush_i || (req_valid_i && !w_ready);
        if (w_close) w_state_next = ISSUE;
      end
      ISSUE: w_state_next = BUSY;
      BUSY: begin
        if (w_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_occ   <= '0;
      r_timer <= '0;
      r_lat   <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_occ            <= w_occ_next;
            r_ctrl.sign_ctrl <= req_sign_i;
            r_ctrl.ch        <= w_ch_set;
            r_timer          <= '0;
          end
        end
        COLLECT: begin
          r_timer <= r_timer + TW'(1);
          if (w_hs) begin
            r_occ     <= w_occ_next;
            r_ctrl.ch <= r_ctrl.ch | w_ch_set;
          end
        end
        ISSUE: r_lat <= LAT_INIT;
        BUSY: begin
          r_lat <= r_lat - LW'(1);
          if (w_done) begin
            r_occ  <= '0;
            r_ctrl <= '0;
          end
        end
        default: r_lat <= '0;
      endcase
    end
  end

  assign req_slot_o     = w_slot;
  assign sort_start_o   = (r_state == ISSUE);
  assign sort_ctrl_o    = r_ctrl;
  assign done_valid_o   = w_done;
  assign done_channel_o = w_done ? r_ctrl.ch : '0;
  assign done_sign_o    = w_done && r_ctrl.sign_ctrl;
  assign idle_o         = (r_state == IDLE);

endmodule

// File: doc/sorter_batch_scheduler.md
Name: sorter_batch_scheduler

Overview:
Front-end controller for the top-k sorter array. It collects independent sort jobs of 4/8/16/32 elements from a single valid/ready request port and packs them into non-overlapping aligned quad slots of the MAX_DATALENGTH window. It drives the sorter's ctrl_t (sign + channel selection) for one batch at a time, times the sorter latency, and signals completion with the batch's channel mask.

Parameters:
SORT_LATENCY, 5, cycles from sort_start_o to the result being valid on the sorter outputs; must be >= 1.
BATCH_TIMEOUT, 8, maximum COLLECT cycles before a partial batch is issued; must be >= 1.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
req_valid_i  in  1  job request valid
req_ready_o  out  1  job accepted when valid && ready
req_size_i  in  2  0=4, 1=8, 2=16, 3=32 elements
req_sign_i  in  1  1=signed compare
req_slot_o  out  3  first quad index assigned; valid in the handshake cycle
flush_i  in  1  close the current batch early
sort_start_o  out  1  one-cycle pulse that launches the sorter
sort_ctrl_o  out  ctrl_t  sign_ctrl plus channel bits; held stable from ISSUE through BUSY
done_valid_o  out  1  one-cycle pulse when the batch result is valid
done_channel_o  out  channel_t  channel mask of the finished batch
done_sign_o  out  1  sign mode of the finished batch
idle_o  out  1  state == IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; occupancy, timer, latency counter and sort_ctrl_o all zero; sort_start_o=0; done_valid_o=0; done_channel_o=0.
- While rst_i=1, req_ready_o is forced to 0.
- Reset in any state discards the batch. No done pulse is produced for it.
- Slots: NUM_QUADS = MAX_DATALENGTH/4 = 8. Alignment and first-fit placement per size:
  - 4: any single quad.
  - 8: even quad pair.
  - 16: quads 4k..4k+3.
  - 32: quads 0..7.
  - Placement is first-fit at the lowest free aligned index.
- Channel bit mapping for a job at quad q:
  - 4 → channel_4[q]
  - 8 → channel_8[q/2]
  - 16 → channel_16[q/4]
  - 32 → channel_32
- Fit: a job fits if its aligned block is entirely free.
- States:
  - IDLE
    - req_ready_o=1.
    - On handshake: allocate, latch sign, clear timer, go COLLECT.
    - flush_i is ignored; an empty batch is never issued.
  - COLLECT
    - req_ready_o = fits && (req_sign_i == latched sign) && !full.
    - Timer increments every cycle.
    - Go to ISSUE after the current cycle if any of these holds:
      - occupancy becomes full;
      - timer == BATCH_TIMEOUT-1;
      - flush_i=1;
      - req_valid_i=1 with ready=0 (sign mismatch or no fit).
    - A request accepted in the closing cycle is included in the batch.
    - A refused request must be held by the requester and is accepted after the batch completes.
  - ISSUE
    - One cycle; sort_start_o=1; req_ready_o=0.
    - Load latency counter with SORT_LATENCY; go BUSY.
  - BUSY
    - req_ready_o=0; counter decrements each cycle.
    - done_valid_o, done_channel_o and done_sign_o are asserted exactly SORT_LATENCY cycles after the sort_start_o cycle, in the last BUSY cycle.
    - Next state IDLE; occupancy is cleared.
- Timing: first job accepted at cycle t → COLLECT t+1..t+BATCH_TIMEOUT (unless closed earlier) → ISSUE t+BATCH_TIMEOUT+1.
- sort_ctrl_o updates only on acceptance; it is zero after reset and after done.

Decomposition:
- sorter_pkg additions:
  - NUM_QUADS constant;
  - job_size_e enum {SZ4, SZ8, SZ16, SZ32};
  - sched_state_e {IDLE, COLLECT, ISSUE, BUSY}.
- ctrl_t and channel_t are reused unchanged.
- One combinational sub-module, sorter_slot_alloc. Inputs: occupancy[7:0], size. Outputs: fit, slot, new occupancy mask, channel_t bit to set.

Test Plan:
1. One SZ4 job, sign 0, accepted at cycle 0, nothing else.
   - slot 0; ISSUE at cycle 9 with channel_4=8'b00000001, sign_ctrl=0.
   - done_valid_o at cycle 14.
2. Jobs SZ16, SZ8, SZ4, SZ4 back-to-back, all sign 1.
   - slots 0, 4, 6, 7; full, so ISSUE the next cycle.
   - channel_16=2'b01, channel_8=4'b0100, channel_4=8'b11000000, channel_32=0.
3. SZ4 sign 0, then SZ4 sign 1 held valid.
   - second request refused; batch issues with channel_4=8'b00000001.
   - after done, second request accepted in IDLE with slot 0 and sign_ctrl=1.
4. SZ4 job, then SZ32.
   - SZ32 does not fit; ready=0; batch closes.
   - SZ32 later accepted alone; channel_32=1.
5. SZ8 accepted in the same cycle as flush_i=1 during COLLECT (after an earlier SZ4).
   - SZ8 is included: channel_4=8'b00000001, channel_8=4'b0010.
   - ISSUE on the next cycle.
6. rst_i pulsed during BUSY.
   - no done_valid_o; sort_ctrl_o=0.
   - idle_o=1 and req_ready_o=1 on the first cycle after reset deasserts.
